// File: rtl/conv1_pkg.sv
// Shared constants, FSM state encoding and window-count helper for the conv1 frame scheduler.
package conv1_pkg;

  localparam int FILTER_SIZE = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FEED  = 3'd2,
    ST_PAD   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Number of valid 3x3 windows a width x height stream produces.
  function automatic int n_win(input int width, input int height);
    return (width - FILTER_SIZE + 1) * (height - FILTER_SIZE + 1);
  endfunction

endpackage

// File: rtl/conv1_sched_if.sv
// Stream bundle between the scheduler, the upstream frame FIFO and the 3x3 window line buffer.
interface conv1_sched_if #(
  parameter int DATA_BITS = 32
);
  logic                 frame_avail;
  logic                 img_valid;
  logic [DATA_BITS-1:0] img_data;
  logic                 img_rd;
  logic                 buf_rst_n;
  logic [DATA_BITS-1:0] buf_data;
  logic                 win_valid;

  modport master (
    input  frame_avail, img_valid, img_data, win_valid,
    output img_rd, buf_rst_n, buf_data
  );

  modport slave (
    output frame_avail, img_valid, img_data, win_valid,
    input  img_rd, buf_rst_n, buf_data
  );
endinterface

// File: rtl/conv1_wdog.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags TIMEOUT reached.
module conv1_wdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT));

  // Counter holds at TIMEOUT until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/conv1_sched.sv
// Frame scheduler for the conv1 3x3 line buffer: clear, stream one FIFO frame, zero-pad,
// then wait for all windows (with watchdog) and report completion and errors.
module conv1_sched
  import conv1_pkg::*;
#(
  parameter int WIDTH     = 28,
  parameter int HEIGHT    = 36,
  parameter int IMG_H     = 28,
  parameter int DATA_BITS = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  conv1_sched_if.master        bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_underflow_o,
  output logic                 err_timeout_o,
  output logic [9:0]           win_cnt_o
);
  localparam int          FEED_LEN = IMG_H * WIDTH;
  localparam int          TOTAL    = HEIGHT * WIDTH;
  localparam int          PW       = $clog2(TOTAL);
  localparam logic [9:0]  N_WIN_C  = 10'(n_win(WIDTH, HEIGHT));
  localparam state_e      AFTER_FEED = (HEIGHT > IMG_H) ? ST_PAD : ST_DRAIN;

  state_e                state_q, state_d, nxt_s;
  logic [PW-1:0]         pix_q, pix_d;
  logic [9:0]            win_cnt_q, win_cnt_d;
  logic [DATA_BITS-1:0]  buf_data_q, buf_data_d;
  logic                  buf_rst_n_q, buf_rst_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  eu_q, eu_d;
  logic                  et_q, et_d;
  logic                  rd_s, win_inc_s, wdog_clr_s, wdog_en_s, wdog_exp_s;

  // abort gates the read strobe in the same cycle so no FIFO word is consumed.
  assign rd_s       = (state_q == ST_FEED) && !abort_i;
  assign bus.img_rd = rd_s;
  assign win_inc_s  = bus.win_valid && (win_cnt_q != N_WIN_C);
  assign wdog_en_s  = (state_q == ST_DRAIN);
  assign wdog_clr_s = (state_q != ST_DRAIN) || bus.win_valid;

  conv1_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wdog_clr_s),
    .en_i      (wdog_en_s),
    .expired_o (wdog_exp_s)
  );

  always_comb begin
    nxt_s = state_q;
    case (state_q)
      ST_IDLE:  nxt_s = (start_i && bus.frame_avail) ? ST_CLR : ST_IDLE;
      ST_CLR:   nxt_s = ST_FEED;
      ST_FEED:  nxt_s = (pix_q == PW'(FEED_LEN - 1)) ? AFTER_FEED : ST_FEED;
      ST_PAD:   nxt_s = (pix_q == PW'(TOTAL - 1)) ? ST_DRAIN : ST_PAD;
      ST_DRAIN: nxt_s = ((win_cnt_q == N_WIN_C) || wdog_exp_s) ? ST_DONE : ST_DRAIN;
      ST_DONE:  nxt_s = ST_IDLE;
      default:  nxt_s = ST_IDLE;
    endcase
    state_d = abort_i ? ST_IDLE : nxt_s;
  end

  always_comb begin
    pix_d      = pix_q;
    win_cnt_d  = win_cnt_q;
    eu_d       = eu_q;
    et_d       = et_q;
    buf_data_d = '0;
    case (state_q)
      ST_CLR: begin
        pix_d     = '0;
        win_cnt_d = '0;
        eu_d      = 1'b0;
        et_d      = 1'b0;
      end
      ST_FEED: begin
        pix_d      = pix_q + {{(PW-1){1'b0}}, 1'b1};
        win_cnt_d  = win_cnt_q + {9'd0, win_inc_s};
        buf_data_d = (rd_s && bus.img_valid) ? bus.img_data : '0;
        eu_d       = eu_q | (rd_s & ~bus.img_valid);
      end
      ST_PAD: begin
        pix_d     = pix_q + {{(PW-1){1'b0}}, 1'b1};
        win_cnt_d = win_cnt_q + {9'd0, win_inc_s};
      end
      ST_DRAIN: begin
        win_cnt_d = win_cnt_q + {9'd0, win_inc_s};
        // Timeout only counts as an error if the frame was not already complete.
        et_d      = et_q | (wdog_exp_s & (win_cnt_q != N_WIN_C));
      end
      default: begin
        pix_d = pix_q;
      end
    endcase
  end

  assign buf_rst_n_d = (state_d != ST_CLR) && !abort_i;
  assign busy_d      = (state_d != ST_IDLE);
  assign done_d      = (state_d == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pix_q       <= '0;
      win_cnt_q   <= '0;
      buf_data_q  <= '0;
      buf_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      eu_q        <= 1'b0;
      et_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      win_cnt_q   <= win_cnt_d;
      buf_data_q  <= buf_data_d;
      buf_rst_n_q <= buf_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      eu_q        <= eu_d;
      et_q        <= et_d;
    end
  end

  assign bus.buf_rst_n   = buf_rst_n_q;
  assign bus.buf_data    = buf_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_underflow_o = eu_q;
  assign err_timeout_o   = et_q;
  assign win_cnt_o       = win_cnt_q;
endmodule

// File: tb/tb_conv1_sched.sv
// Randomized bench for conv1_sched: FIFO and 3x3 line-buffer models drive the DUT, a frame-level
// reference (stream contents, window totals, completion time, error flags) checks it.
module tb_conv1_sched;
  import conv1_pkg::*;

  localparam int W   = 28;
  localparam int HA  = 36;
  localparam int HB  = 28;
  localparam int IH  = 28;
  localparam int DB  = 32;
  localparam int TMO = 256;
  localparam int BIG = 100000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic start_v = 1'b0, abort_v = 1'b0;
  logic frame_avail = 1'b0, img_valid = 1'b0, win_valid = 1'b0;
  logic [DB-1:0] img_data = '0;

  logic busy_a, done_a, eu_a, et_a, busy_b, done_b, eu_b, et_b;
  logic [9:0] wc_a, wc_b;

  conv1_sched_if #(.DATA_BITS(DB)) bus_a ();
  conv1_sched_if #(.DATA_BITS(DB)) bus_b ();

  assign bus_a.frame_avail = frame_avail;
  assign bus_a.img_valid   = img_valid;
  assign bus_a.img_data    = img_data;
  assign bus_a.win_valid   = win_valid;
  assign bus_b.frame_avail = frame_avail;
  assign bus_b.img_valid   = img_valid;
  assign bus_b.img_data    = img_data;
  assign bus_b.win_valid   = win_valid;

  conv1_sched #(.WIDTH(W), .HEIGHT(HA), .IMG_H(IH), .DATA_BITS(DB), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_v & ~sel), .abort_i(abort_v), .bus(bus_a.master),
    .busy_o(busy_a), .done_o(done_a), .err_underflow_o(eu_a), .err_timeout_o(et_a), .win_cnt_o(wc_a)
  );

  conv1_sched #(.WIDTH(W), .HEIGHT(HB), .IMG_H(IH), .DATA_BITS(DB), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_v & sel), .abort_i(abort_v), .bus(bus_b.master),
    .busy_o(busy_b), .done_o(done_b), .err_underflow_o(eu_b), .err_timeout_o(et_b), .win_cnt_o(wc_b)
  );

  wire          o_busy      = sel ? busy_b : busy_a;
  wire          o_done      = sel ? done_b : done_a;
  wire          o_eu        = sel ? eu_b : eu_a;
  wire          o_et        = sel ? et_b : et_a;
  wire [9:0]    o_wc        = sel ? wc_b : wc_a;
  wire          o_img_rd    = sel ? bus_b.img_rd : bus_a.img_rd;
  wire          o_buf_rst_n = sel ? bus_b.buf_rst_n : bus_a.buf_rst_n;
  wire [DB-1:0] o_buf_data  = sel ? bus_b.buf_data : bus_a.buf_data;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int hh = HA;
  int bm_cyc = 0;
  bit bm_active = 1'b0;
  int rd_cnt = 0, first_rd = -1, last_rd = -1;
  int done_cnt = 0, done_rel = -1;
  int win_emitted = 0, win_lim = BIG, uf_at = -1;
  logic [DB-1:0] rv[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic int exp_wins(input int h, input int lim);
    int full;
    full = (W - FILTER_SIZE + 1) * (h - FILTER_SIZE + 1);
    return (lim < full) ? lim : full;
  endfunction

  // One clock: observe registered outputs at the falling edge, run the models, drive inputs.
  task automatic tick(input bit st, input bit ab);
    int k;
    logic [DB-1:0] want;
    @(negedge clk);
    if (!o_buf_rst_n) begin
      bm_active = o_busy;
      bm_cyc    = 0;
    end else if (bm_active && o_busy) begin
      bm_cyc++;
    end else begin
      bm_active = 1'b0;
    end
    // Buffer model latches stream word k in the cycle 2+k after its reset cycle.
    k = bm_cyc - 2;
    if (bm_active && k >= 0 && k < hh * W) begin
      if (k < IH * W) want = (k < rv.size()) ? rv[k] : 'x;
      else            want = '0;
      chk("buf_data", o_buf_data, want);
    end
    if (o_done) begin
      done_cnt++;
      done_rel = bm_cyc;
    end
    k = bm_cyc - 3;
    win_valid = bm_active && k >= 0 && k < hh * W && (k / W) >= FILTER_SIZE - 1 &&
                (k % W) >= FILTER_SIZE - 1 && win_emitted < win_lim;
    if (win_valid) win_emitted++;
    img_valid = !(uf_at >= 0 && rd_cnt >= uf_at && rd_cnt < uf_at + 3);
    img_data  = $urandom();
    start_v   = st;
    abort_v   = ab;
    #1;
    if (o_img_rd) begin
      rv.push_back(img_valid ? img_data : '0);
      if (first_rd < 0) first_rd = bm_cyc;
      last_rd = bm_cyc;
      rd_cnt++;
    end
  endtask

  task automatic begin_frame(input bit s, input int uf, input int lim);
    sel = s;
    hh = s ? HB : HA;
    uf_at = uf;
    win_lim = lim;
    rv.delete();
    rd_cnt = 0; first_rd = -1; last_rd = -1;
    done_cnt = 0; done_rel = -1; win_emitted = 0;
  endtask

  task automatic run_to_end(input int st_at);
    int n;
    n = 0;
    tick(1'b1, 1'b0);
    while (!(done_cnt > 0 && !o_busy) && n < 3000) begin
      tick(st_at >= 0 && rd_cnt == st_at, 1'b0);
      n++;
    end
    chk("frame_bound", n < 3000, 1);
  endtask

  task automatic frame_checks(input int exp_win, input bit exp_uf, input bit exp_to, input int exp_done);
    chk("reads", rd_cnt, IH * W);
    chk("rd_first", first_rd, 1);
    chk("rd_contig", last_rd - first_rd + 1, IH * W);
    chk("done_pulses", done_cnt, 1);
    chk("done_time", done_rel, exp_done);
    chk("win_cnt", o_wc, exp_win);
    chk("err_underflow", o_eu, exp_uf);
    chk("err_timeout", o_et, exp_to);
    chk("idle_after", o_busy, 0);
  endtask

  task automatic reset_checks();
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_eu", o_eu, 0);
    chk("rst_et", o_et, 0);
    chk("rst_wc", o_wc, 0);
    chk("rst_buf_rst_n", o_buf_rst_n, 0);
    chk("rst_buf_data", o_buf_data, 0);
    chk("rst_img_rd", o_img_rd, 0);
  endtask

  initial begin
    int n;
    #3;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("idle_buf_rst_n", o_buf_rst_n, 1);

    // start without a frame available is dropped
    frame_avail = 1'b0;
    tick(1'b1, 1'b0);
    repeat (4) tick(1'b0, 1'b0);
    chk("noavail_busy", o_busy, 0);
    frame_avail = 1'b1;
    tick(1'b0, 1'b0);
    chk("noavail_not_queued", o_busy, 0);

    // start and abort together: abort wins
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    chk("start_abort_busy", o_busy, 0);
    tick(1'b0, 1'b0);
    chk("start_abort_busy2", o_busy, 0);

    // nominal frame, with a stray start mid-FEED that must be ignored
    begin_frame(1'b0, -1, BIG);
    run_to_end(50);
    frame_checks(exp_wins(HA, BIG), 1'b0, 1'b0, HA * W + 4);
    repeat (5) tick(1'b0, 1'b0);
    chk("no_requeue_busy", o_busy, 0);
    chk("no_requeue_done", done_cnt, 1);

    // underflow at pixel 100 for 3 reads
    begin_frame(1'b0, 100, BIG);
    run_to_end(-1);
    frame_checks(exp_wins(HA, BIG), 1'b1, 1'b0, HA * W + 4);

    // buffer stalls after 500 windows: watchdog fires TIMEOUT drain cycles after entry
    begin_frame(1'b0, -1, 500);
    run_to_end(-1);
    frame_checks(exp_wins(HA, 500), 1'b0, 1'b1, HA * W + 1 + TMO + 1);

    // abort mid-FEED at pixel 300
    begin_frame(1'b0, -1, BIG);
    tick(1'b1, 1'b0);
    n = 0;
    while (rd_cnt < 300 && n < 2000) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("abort_reach", rd_cnt, 300);
    tick(1'b0, 1'b1);
    chk("abort_rd_same", o_img_rd, 0);
    tick(1'b0, 1'b0);
    chk("abort_busy", o_busy, 0);
    chk("abort_buf_rst_low", o_buf_rst_n, 0);
    chk("abort_rd_next", o_img_rd, 0);
    tick(1'b0, 1'b0);
    chk("abort_buf_rst_high", o_buf_rst_n, 1);
    repeat (20) tick(1'b0, 1'b0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_reads", rd_cnt, 300);
    begin_frame(1'b0, -1, BIG);
    run_to_end(-1);
    frame_checks(exp_wins(HA, BIG), 1'b0, 1'b0, HA * W + 4);

    // HEIGHT == IMG_H instance: no padding rows
    begin_frame(1'b1, -1, BIG);
    run_to_end(-1);
    frame_checks(exp_wins(HB, BIG), 1'b0, 1'b0, HB * W + 4);

    // async reset asserted mid-PAD, between clock edges
    begin_frame(1'b0, 5, BIG);
    tick(1'b1, 1'b0);
    n = 0;
    while (!(bm_active && bm_cyc >= 900) && n < 2000) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("pad_reached", bm_cyc, 900);
    chk("pre_rst_eu", o_eu, 1);
    chk("pre_rst_wc_nonzero", o_wc != 10'd0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(1'b0, 1'b0);
    chk("post_rst_idle", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
